// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC register plus a small in-order queue between imem and decode.
// Ports: clk/rst, imem_addr/imem_instr, redirect_valid/redirect_pc, out_* to decode, halted, occupancy.
`timescale 1ns/1ps

module fetch_queue #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          QDEPTH     = 2,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0063
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        halted,
  output logic [3:0]  occupancy
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [3:0] DEPTH4 = 4'(QDEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]    occ_q, occ_d;
  logic          halted_q, halted_d;

  logic [31:0]   pc_mem_q    [QDEPTH];
  logic [31:0]   pc_mem_d    [QDEPTH];
  logic [31:0]   instr_mem_q [QDEPTH];
  logic [31:0]   instr_mem_d [QDEPTH];

  logic full;
  logic empty;
  logic enq;
  logic deq;

  // Redirect targets are word aligned; the low bits are dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign full  = (occ_q == DEPTH4);
  assign empty = (occ_q == 4'd0);

  // Full blocks enqueue even when the head leaves this cycle,
  // so the entry count never depends on the decode handshake.
  assign enq = !full && !halted_q && !redirect_valid;
  assign deq = !empty && out_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    halted_d    = halted_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = 4'd0;
      halted_d   = 1'b0;
    end else begin
      if (enq) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_q;
        instr_mem_d[wr_ptr_q] = imem_instr;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        fetch_pc_d            = fetch_pc_q + 32'd4;
        if (imem_instr == HALT_INSTR) begin
          halted_d = 1'b1;
        end
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({enq, deq})
        2'b10:   occ_d = occ_q + 4'd1;
        2'b01:   occ_d = occ_q - 4'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= 4'd0;
      halted_q   <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        pc_mem_q[i]    <= 32'h0;
        instr_mem_q[i] <= 32'h0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      halted_q    <= halted_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = !empty;
  assign occupancy = occ_q;
  assign halted    = halted_q;

  // Stale slots stay hidden: an empty queue presents zeros.
  assign out_pc    = empty ? 32'h0 : pc_mem_q[rd_ptr_q];
  assign out_instr = empty ? 32'h0 : instr_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard of expected deliveries.
// Two instances: default RESET_PC, and RESET_PC near the top of the address space.
`timescale 1ns/1ps

module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, rst1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready, ready1;
  logic        halt_en;

  logic [31:0] imem_addr, imem_instr, out_pc, out_instr;
  logic        out_valid, halted;
  logic [3:0]  occupancy;

  logic [31:0] imem_addr1, imem_instr1, out_pc1, out_instr1;
  logic        out_valid1, halted1;
  logic [3:0]  occupancy1;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp0 [$];
  logic [63:0] exp1 [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] word(logic [31:0] a, logic h);
    return (h && a == 32'h10) ? 32'h0000_0063 : (a ^ 32'h0050_0093);
  endfunction

  assign imem_instr  = word(imem_addr, halt_en);
  assign imem_instr1 = word(imem_addr1, 1'b0);

  fetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .halted(halted), .occupancy(occupancy)
  );

  fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst(rst1),
    .imem_addr(imem_addr1), .imem_instr(imem_instr1),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid1), .out_ready(ready1),
    .out_pc(out_pc1), .out_instr(out_instr1),
    .halted(halted1), .occupancy(occupancy1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push0(input logic [31:0] pc, input logic h);
    exp0.push_back({pc, word(pc, h)});
  endtask

  task automatic push1(input logic [31:0] pc);
    exp1.push_back({pc, word(pc, 1'b0)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a handshake on the coming edge consumes one expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !redirect_valid) begin
      if (exp0.size() == 0) begin
        chk("mon0_unexpected_pc", out_pc, 32'hxxxx_xxxx);
      end else begin
        logic [63:0] e;
        e = exp0.pop_front();
        chk("mon0_pc", out_pc, e[63:32]);
        chk("mon0_instr", out_instr, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1 && out_valid1 && ready1) begin
      if (exp1.size() == 0) begin
        chk("mon1_unexpected_pc", out_pc1, 32'hxxxx_xxxx);
      end else begin
        logic [63:0] e;
        e = exp1.pop_front();
        chk("mon1_pc", out_pc1, e[63:32]);
        chk("mon1_instr", out_instr1, e[31:0]);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    out_ready = 1'b0; ready1 = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    halt_en = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst1_addr", imem_addr1, 32'hFFFF_FFF8);
    chk("rst1_valid", 32'(out_valid1), 32'h0);
    tick();

    // Streaming
    for (int i = 0; i < 7; i++) push0(32'(4 * i), 1'b0);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("strm_occ1", 32'(occupancy), 32'd1);
    chk("strm_pc0", out_pc, 32'h0);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("strm_occ", 32'(occupancy), 32'd1);
      chk("strm_addr", imem_addr, 32'(4 * k));
    end
    out_ready = 1'b0;
    tick();
    chk("strm_occ2", 32'(occupancy), 32'd2);
    tick();
    chk("full_hold_addr", imem_addr, 32'd36);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_addr", imem_addr, 32'h0);
    chk("async_rst_occ", 32'(occupancy), 32'h0);
    chk("strm_drained", 32'(exp0.size()), 32'h0);
    tick();

    // Backpressure
    push0(32'h0, 1'b0); push0(32'h4, 1'b0); push0(32'h8, 1'b0);
    rst = 1'b0;
    tick();
    chk("bp_occ1", 32'(occupancy), 32'd1);
    tick();
    chk("bp_occ2", 32'(occupancy), 32'd2);
    chk("bp_pc_e2", out_pc, 32'h0);
    repeat (3) tick();
    chk("bp_occ_hold", 32'(occupancy), 32'd2);
    chk("bp_addr_hold", imem_addr, 32'h8);
    chk("bp_head_pc", out_pc, 32'h0);
    chk("bp_head_instr", out_instr, 32'h0050_0093);
    out_ready = 1'b1;
    tick();
    chk("bp_no_enq_full", imem_addr, 32'h8);
    chk("bp_occ_after", 32'(occupancy), 32'd1);
    tick();
    tick();
    chk("bp_addr_16", imem_addr, 32'h10);
    out_ready = 1'b0;
    tick();
    chk("bp_refill", 32'(occupancy), 32'd2);

    // Redirect from a full queue
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk("rd_occ", 32'(occupancy), 32'h0);
    chk("rd_valid", 32'(out_valid), 32'h0);
    chk("rd_addr", imem_addr, 32'h100);
    push0(32'h100, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("rd_valid_up", 32'(out_valid), 32'h1);
    chk("rd_head", out_pc, 32'h100);
    tick();
    chk("rd_head2", out_pc, 32'h104);
    // Redirect wins over an accepted head: 0x104 is discarded.
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    halt_en = 1'b1;
    push0(32'h8, 1'b1); push0(32'hC, 1'b1); push0(32'h10, 1'b1);
    tick();
    redirect_valid = 1'b0;
    chk("rd2_occ", 32'(occupancy), 32'h0);

    // Halt
    tick();
    tick();
    tick();
    chk("halt_set", 32'(halted), 32'h1);
    chk("halt_addr", imem_addr, 32'h14);
    chk("halt_head", out_instr, 32'h0000_0063);
    tick();
    chk("halt_drain_occ", 32'(occupancy), 32'h0);
    chk("halt_drain_valid", 32'(out_valid), 32'h0);
    tick();
    tick();
    chk("halt_idle_valid", 32'(out_valid), 32'h0);
    chk("halt_idle_addr", imem_addr, 32'h14);
    chk("halt_stays", 32'(halted), 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    chk("unhalt", 32'(halted), 32'h0);
    chk("unhalt_addr", imem_addr, 32'h0);
    push0(32'h0, 1'b1); push0(32'h4, 1'b1);
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    chk("restart_occ", 32'(occupancy), 32'd2);
    rst = 1'b1;
    #1;
    chk("rst2_valid", 32'(out_valid), 32'h0);
    chk("rst2_addr", imem_addr, 32'h0);
    chk("halt_drained", 32'(exp0.size()), 32'h0);
    tick();

    // Wrap and mid-stream reset on the high RESET_PC instance
    push1(32'hFFFF_FFF8); push1(32'hFFFF_FFFC); push1(32'h0);
    rst1 = 1'b0; ready1 = 1'b1;
    tick();
    chk("wrap_head", out_pc1, 32'hFFFF_FFF8);
    tick();
    tick();
    chk("wrap_addr", imem_addr1, 32'h4);
    chk("wrap_occ", 32'(occupancy1), 32'd1);
    tick();
    ready1 = 1'b0;
    tick();
    chk("wrap_occ2", 32'(occupancy1), 32'd2);
    rst1 = 1'b1;
    #1;
    chk("wrap_rst_valid", 32'(out_valid1), 32'h0);
    chk("wrap_rst_addr", imem_addr1, 32'hFFFF_FFF8);
    chk("wrap_rst_occ", 32'(occupancy1), 32'h0);
    tick();
    chk("wrap_drained", 32'(exp1.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
